// File: rtl/bubble_sort_controller_pkg.sv
// Shared types for the bubble-sort sequencer: FSM state encoding and element width.
package sort_pkg;

    localparam int DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COMP  = 3'd2,
        ST_SWAP1 = 3'd3,
        ST_SWAP2 = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/bubble_sort_controller_if.sv
// Handshake and memory/operand control bundle between the sort sequencer and its datapath.
interface bubble_sort_controller_if #(
    parameter int AW = 3
);
    logic          start;
    logic          a_gt_b;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          op_en;
    logic          op_ld;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_sel;
    logic          busy;
    logic          done;

    modport master (
        input  start, a_gt_b,
        output rd_addr_a, rd_addr_b, op_en, op_ld, wr_en, wr_addr, wr_sel, busy, done
    );

    modport slave (
        output start, a_gt_b,
        input  rd_addr_a, rd_addr_b, op_en, op_ld, wr_en, wr_addr, wr_sel, busy, done
    );
endinterface

// File: rtl/bubble_sort_controller_sort_index_counter.sv
// Pass index i and element index j for the sort, plus end-of-pass and last-pass detection.
module sort_index_counter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc_j,
    input  logic          next_pass,
    output logic [AW-1:0] i,
    output logic [AW-1:0] j,
    output logic [AW-1:0] j_plus1,
    output logic          end_of_pass,
    output logic          last_pass
);

    localparam logic [AW-1:0] LAST = AW'(N - 2);

    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (next_pass) begin
            i_d = i_q + AW'(1);
            j_d = '0;
        end else if (inc_j) begin
            j_d = j_q + AW'(1);
        end
    end

    // Pass i compares pairs j = 0 .. N-2-i, so j+1 never exceeds N-1.
    assign end_of_pass = (j_q == (LAST - i_q));
    assign last_pass   = (i_q == LAST);
    assign i           = i_q;
    assign j           = j_q;
    assign j_plus1     = j_q + AW'(1);

endmodule

// File: rtl/bubble_sort_controller.sv
// Bubble-sort sequencer: walks an external element memory through load/compare/swap steps.
module bubble_sort_controller
    import sort_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic clk,
    input  logic rst,
    bubble_sort_controller_if.master bus
);

    // state | meaning
    // IDLE  | waiting for start; outputs all zero
    // LOAD  | load operand regs from elements j and j+1
    // COMP  | evaluate datapath comparator
    // SWAP1 | write operand B to element j
    // SWAP2 | write operand A to element j+1
    // NEXT  | advance j, start a new pass, or finish
    // DONE  | one-cycle completion pulse

    state_e        state_q, state_d;
    logic          swapped_q, swapped_d;
    logic          clr, inc_j, next_pass;
    logic [AW-1:0] idx_i, idx_j, idx_j1;
    logic          end_of_pass, last_pass;

    logic          op_en_o, op_ld_o, wr_en_o, wr_sel_o, busy_o, done_o;
    logic [AW-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_o;

    sort_index_counter #(
        .N  (N),
        .AW (AW)
    ) u_index (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .inc_j       (inc_j),
        .next_pass   (next_pass),
        .i           (idx_i),
        .j           (idx_j),
        .j_plus1     (idx_j1),
        .end_of_pass (end_of_pass),
        .last_pass   (last_pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            swapped_q <= swapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        swapped_d = swapped_q;
        clr       = 1'b0;
        inc_j     = 1'b0;
        next_pass = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clr       = 1'b1;
                    swapped_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_COMP;
            ST_COMP:  state_d = bus.a_gt_b ? ST_SWAP1 : ST_NEXT;
            ST_SWAP1: begin
                swapped_d = 1'b1;
                state_d   = ST_SWAP2;
            end
            ST_SWAP2: state_d = ST_NEXT;
            ST_NEXT: begin
                if (!end_of_pass) begin
                    inc_j   = 1'b1;
                    state_d = ST_LOAD;
                end else if (!swapped_q || last_pass) begin
                    state_d = ST_DONE;
                end else begin
                    next_pass = 1'b1;
                    swapped_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Addresses are forced to zero whenever their strobe is idle.
    always_comb begin
        op_en_o     = 1'b0;
        op_ld_o     = 1'b0;
        wr_en_o     = 1'b0;
        wr_sel_o    = 1'b0;
        rd_addr_a_o = '0;
        rd_addr_b_o = '0;
        wr_addr_o   = '0;
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        case (state_q)
            ST_LOAD: begin
                op_en_o     = 1'b1;
                op_ld_o     = 1'b1;
                rd_addr_a_o = idx_j;
                rd_addr_b_o = idx_j1;
            end
            ST_SWAP1: begin
                wr_en_o   = 1'b1;
                wr_addr_o = idx_j;
                wr_sel_o  = 1'b1;
            end
            ST_SWAP2: begin
                wr_en_o   = 1'b1;
                wr_addr_o = idx_j1;
                wr_sel_o  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.op_en     = op_en_o;
    assign bus.op_ld     = op_ld_o;
    assign bus.wr_en     = wr_en_o;
    assign bus.wr_sel    = wr_sel_o;
    assign bus.wr_addr   = wr_addr_o;
    assign bus.rd_addr_a = rd_addr_a_o;
    assign bus.rd_addr_b = rd_addr_b_o;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;

    logic unused_i;
    assign unused_i = ^idx_i;

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Bench for bubble_sort_controller: N=4 and N=2 instances against a per-compare trace model of bubble sort.
module tb_bubble_sort_controller;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       op_en;
        logic       op_ld;
        logic       wr_en;
        logic       ws;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] wa;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start4 = 1'b0, start2 = 1'b0, ld4 = 1'b0, ld2 = 1'b0;
    logic [15:0] init4 [4];
    logic [15:0] mem4  [4];
    logic [15:0] init2 [2];
    logic [15:0] mem2  [2];
    logic [15:0] opa4, opb4, opa2, opb2;

    bubble_sort_controller_if #(.AW(2)) b4 ();
    bubble_sort_controller_if #(.AW(1)) b2 ();

    assign b4.start  = start4;
    assign b2.start  = start2;
    assign b4.a_gt_b = (opa4 > opb4);
    assign b2.a_gt_b = (opa2 > opb2);

    bubble_sort_controller #(.N(4), .AW(2)) u4 (.clk(clk), .rst(rst), .bus(b4.master));
    bubble_sort_controller #(.N(2), .AW(1)) u2 (.clk(clk), .rst(rst), .bus(b2.master));

    // Element memories and operand registers the sequencer drives.
    always @(posedge clk) begin
        if (ld4) begin
            for (int k = 0; k < 4; k++) mem4[k] <= init4[k];
        end else if (b4.wr_en) begin
            mem4[b4.wr_addr] <= b4.wr_sel ? opb4 : opa4;
        end
        if (b4.op_en && b4.op_ld) begin
            opa4 <= mem4[b4.rd_addr_a];
            opb4 <= mem4[b4.rd_addr_b];
        end
    end

    always @(posedge clk) begin
        if (ld2) begin
            for (int k = 0; k < 2; k++) mem2[k] <= init2[k];
        end else if (b2.wr_en) begin
            mem2[b2.wr_addr] <= b2.wr_sel ? opb2 : opa2;
        end
        if (b2.op_en && b2.op_ld) begin
            opa2 <= mem2[b2.rd_addr_a];
            opb2 <= mem2[b2.rd_addr_b];
        end
    end

    int   n_cmp = 0, n_err = 0, cyc = 0;
    exp_t q4[$], q2[$], model_tr[$];
    logic [15:0] model_res[$];
    int   wr_cnt[2], done_cnt[2], done_cyc[2], bnd_cnt[2];

    function automatic exp_t mk(bit b, bit d, bit en, bit we, bit ws, int ra, int rb, int wa);
        exp_t e;
        e.busy = b; e.done = d; e.op_en = en; e.op_ld = en; e.wr_en = we; e.ws = ws;
        e.ra = 8'(ra); e.rb = 8'(rb); e.wa = 8'(wa);
        return e;
    endfunction

    function automatic exp_t sample(int s);
        exp_t a;
        if (s == 0) begin
            a.busy = b4.busy; a.done = b4.done; a.op_en = b4.op_en; a.op_ld = b4.op_ld;
            a.wr_en = b4.wr_en; a.ws = b4.wr_sel;
            a.ra = 8'(b4.rd_addr_a); a.rb = 8'(b4.rd_addr_b); a.wa = 8'(b4.wr_addr);
        end else begin
            a.busy = b2.busy; a.done = b2.done; a.op_en = b2.op_en; a.op_ld = b2.op_ld;
            a.wr_en = b2.wr_en; a.ws = b2.wr_sel;
            a.ra = 8'(b2.rd_addr_a); a.rb = 8'(b2.rd_addr_b); a.wa = 8'(b2.wr_addr);
        end
        return a;
    endfunction

    // Idle cycles must be all-zero; otherwise addresses only matter under their strobe.
    function automatic bit match(exp_t e, exp_t a);
        if (!e.busy) return (a == e);
        if (e.busy != a.busy || e.done != a.done || e.op_en != a.op_en ||
            e.op_ld != a.op_ld || e.wr_en != a.wr_en) return 1'b0;
        if (e.op_en && (e.ra != a.ra || e.rb != a.rb)) return 1'b0;
        if (e.wr_en && (e.wa != a.wa || e.ws != a.ws)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int qsize(int s);
        return (s == 0) ? q4.size() : q2.size();
    endfunction

    function automatic int mem_at(int s, int k);
        return (s == 0) ? int'(mem4[k]) : int'(mem2[k]);
    endfunction

    task automatic check(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Plain bubble sort with early exit; each compare is load, compare, optional two writes, advance.
    task automatic model_sort(input int n, input logic [15:0] din[$]);
        logic [15:0] a[$];
        logic [15:0] t;
        bit sw;
        a = din;
        model_tr.delete();
        model_tr.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < n - 1; i++) begin
            sw = 1'b0;
            for (int j = 0; j <= n - 2 - i; j++) begin
                model_tr.push_back(mk(1, 0, 1, 0, 0, j, j + 1, 0));
                model_tr.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    model_tr.push_back(mk(1, 0, 0, 1, 1, 0, 0, j));
                    model_tr.push_back(mk(1, 0, 0, 1, 0, 0, 0, j + 1));
                    sw = 1'b1;
                end
                model_tr.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
            end
            if (!sw) break;
        end
        model_tr.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        model_res = a;
    endtask

    task automatic step();
        exp_t e, a;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            a = sample(s);
            e = '0;
            if (s == 0 && q4.size() > 0) e = q4.pop_front();
            if (s == 1 && q2.size() > 0) e = q2.pop_front();
            n_cmp++;
            if (!match(e, a)) begin
                n_err++;
                $display("FAIL cycle %0d dut%0d outputs: got %h expected %h", cyc, s, a, e);
            end
            wr_cnt[s]   += int'(a.wr_en);
            done_cnt[s] += int'(a.done);
            if (a.done) done_cyc[s] = cyc;
            if (a.busy && !a.done) bnd_cnt[s]++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_sort(input int s, input logic [15:0] din[$], input bit hold,
                            output int lat, output int wrs, output int dns, output int bnd);
        int n, w0, d0, b0, c0;
        n  = (s == 0) ? 4 : 2;
        w0 = wr_cnt[s]; d0 = done_cnt[s]; b0 = bnd_cnt[s];
        model_sort(n, din);
        if (s == 0) begin
            q4 = model_tr;
            for (int k = 0; k < 4; k++) init4[k] = din[k];
            ld4 = 1'b1; start4 = 1'b1;
        end else begin
            q2 = model_tr;
            for (int k = 0; k < 2; k++) init2[k] = din[k];
            ld2 = 1'b1; start2 = 1'b1;
        end
        c0 = cyc;
        done_cyc[s] = -1000;
        step();
        ld4 = 1'b0; ld2 = 1'b0;
        if (!hold) begin start4 = 1'b0; start2 = 1'b0; end
        for (int t = 0; t < 2000 && qsize(s) > 0; t++) begin
            if (hold && qsize(s) == 1) begin start4 = 1'b0; start2 = 1'b0; end
            step();
        end
        check("trace drained", qsize(s), 0);
        start4 = 1'b0; start2 = 1'b0;
        step();
        step();
        lat = done_cyc[s] - c0;
        wrs = wr_cnt[s] - w0;
        dns = done_cnt[s] - d0;
        bnd = bnd_cnt[s] - b0;
        for (int k = 0; k < n; k++) check("result vs model", mem_at(s, k), int'(model_res[k]));
    endtask

    task automatic check_mem4(string name, int e0, int e1, int e2, int e3);
        check(name, mem_at(0, 0), e0);
        check(name, mem_at(0, 1), e1);
        check(name, mem_at(0, 2), e2);
        check(name, mem_at(0, 3), e3);
    endtask

    initial begin
        logic [15:0] d[$];
        int lat, wrs, dns, bnd;
        for (int s = 0; s < 2; s++) begin
            wr_cnt[s] = 0; done_cnt[s] = 0; done_cyc[s] = 0; bnd_cnt[s] = 0;
        end

        // Reset with start asserted on the same edges: reset must win.
        rst = 1'b1; start4 = 1'b1; start2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        check("reset busy", int'(b4.busy), 0);
        check("reset done", int'(b4.done), 0);
        rst = 1'b0; start4 = 1'b0; start2 = 1'b0;
        step();

        d = '{16'd3, 16'd1, 16'd2, 16'd0};
        run_sort(0, d, 1'b0, lat, wrs, dns, bnd);
        check("mixed latency", lat, 29);
        check("mixed writes", wrs, 10);
        check("mixed done pulses", dns, 1);
        check_mem4("mixed result", 0, 1, 2, 3);

        d = '{16'd0, 16'd1, 16'd2, 16'd3};
        run_sort(0, d, 1'b0, lat, wrs, dns, bnd);
        check("sorted latency", lat, 10);
        check("sorted writes", wrs, 0);
        check("sorted done pulses", dns, 1);

        d = '{16'd3, 16'd2, 16'd1, 16'd0};
        run_sort(0, d, 1'b0, lat, wrs, dns, bnd);
        check("reversed writes", wrs, 12);
        check("reversed compare cycles", bnd, 30);
        check("reversed latency", lat, 31);
        check_mem4("reversed result", 0, 1, 2, 3);

        d = '{16'd3, 16'd1, 16'd2, 16'd0};
        run_sort(0, d, 1'b1, lat, wrs, dns, bnd);
        check("held start done pulses", dns, 1);
        check("held start latency", lat, 29);
        check_mem4("held start result", 0, 1, 2, 3);

        d = '{16'd2, 16'd2, 16'd1, 16'd2};
        run_sort(0, d, 1'b0, lat, wrs, dns, bnd);
        check("dup writes", wrs, 4);
        check("dup latency", lat, 23);
        check_mem4("dup result", 1, 2, 2, 2);

        // Reset landing while the first swap write is in progress.
        d = '{16'd3, 16'd1, 16'd2, 16'd0};
        model_sort(4, d);
        q4 = model_tr;
        for (int k = 0; k < 4; k++) init4[k] = d[k];
        ld4 = 1'b1; start4 = 1'b1;
        step();
        ld4 = 1'b0; start4 = 1'b0;
        step();
        step();
        check("in swap1 wr_en", int'(b4.wr_en), 1);
        rst = 1'b1;
        step();
        check("after rst busy", int'(b4.busy), 0);
        check("after rst wr_en", int'(b4.wr_en), 0);
        rst = 1'b0;
        q4.delete();
        run_sort(0, d, 1'b0, lat, wrs, dns, bnd);
        check("post-rst latency", lat, 29);
        check_mem4("post-rst result", 0, 1, 2, 3);

        d = '{16'd5, 16'd1};
        run_sort(1, d, 1'b0, lat, wrs, dns, bnd);
        check("n2 latency", lat, 6);
        check("n2 writes", wrs, 2);
        check("n2 result0", mem_at(1, 0), 1);
        check("n2 result1", mem_at(1, 1), 5);

        d = '{16'd1, 16'd5};
        run_sort(1, d, 1'b0, lat, wrs, dns, bnd);
        check("n2 sorted latency", lat, 4);
        check("n2 sorted writes", wrs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bubble_sort_controller.md
BUBBLE_SORT_CONTROLLER -- requirements
Module: bubble_sort_controller

Interface
REQ-001 Parameter N, default 8, number of 16-bit elements to sort; legal range 2..256.
REQ-002 Parameter AW, default 3, address width, equal to ceil(log2(N)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to sort; sampled only in IDLE.
REQ-006 a_gt_b  input  1  datapath comparator result: operand A > operand B (unsigned 16-bit).
REQ-007 rd_addr_a  output  AW  element read address for operand A; equals j.
REQ-008 rd_addr_b  output  AW  element read address for operand B; equals j+1.
REQ-009 op_en  output  1  enable for both operand registers.
REQ-010 op_ld  output  1  load for both operand registers.
REQ-011 wr_en  output  1  element memory write strobe.
REQ-012 wr_addr  output  AW  element memory write address.
REQ-013 wr_sel  output  1  write data select: 1 = operand B, 0 = operand A.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when sorting completes.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, COMP, SWAP1, SWAP2, NEXT and DONE.
REQ-017 IDLE with start=1 SHALL clear i, j and the swapped flag, then go to LOAD.
REQ-018 IDLE with start=0 SHALL stay in IDLE.
REQ-019 LOAD SHALL drive op_en=op_ld=1 with rd_addr_a=j and rd_addr_b=j+1, then go to COMP.
REQ-020 COMP SHALL go to SWAP1 if a_gt_b=1, else to NEXT.
REQ-021 COMP SHALL sample a_gt_b in that cycle only.
REQ-022 SWAP1 SHALL drive wr_en=1, wr_addr=j and wr_sel=1, set swapped=1, then go to SWAP2.
REQ-023 SWAP2 SHALL drive wr_en=1, wr_addr=j+1 and wr_sel=0, then go to NEXT.
REQ-024 NEXT with j < N-2-i SHALL increment j and go to LOAD.
REQ-025 NEXT at end of pass (j == N-2-i), with swapped=0 or i == N-2, SHALL go to DONE.
REQ-026 NEXT at end of pass otherwise SHALL increment i, clear j and swapped, and go to LOAD.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-028 start SHALL be ignored while busy=1; no queuing.
REQ-029 Strobes op_en, op_ld and wr_en SHALL be 0 in every state not listed above for them.
REQ-030 Address outputs SHALL be don't-care when their strobe is low, but SHALL be driven to 0 in IDLE.
REQ-031 i and j SHALL be AW bits wide; j+1 SHALL never exceed N-1.
REQ-032 Latency per compare SHALL be 3 cycles without a swap and 5 cycles with a swap; DONE adds 1 cycle.
REQ-033 N=2 SHALL complete after a single compare; pass 0 is also the final pass.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, clear i, j and swapped, and drive all outputs to 0, from any state including mid-swap.
REQ-035 rst SHALL take priority over start on the same edge.
REQ-036 After rst deasserts, the block SHALL accept start on the next cycle.

Structure
REQ-037 A shared package sort_pkg SHALL hold the FSM state enum and the data width constant DW=16.
REQ-038 The i/j index counters and end-of-pass compare SHALL be one sub-module, sort_index_counter.
REQ-039 The FSM and output decode SHALL remain in bubble_sort_controller.
REQ-040 The operand registers, comparator and element memory are external to this block.

Verification
REQ-041 N=4, data [3,1,2,0], start pulse -> memory reads [0,1,2,3]; done pulses once; busy falls with done.
REQ-042 N=4, already sorted [0,1,2,3] -> no wr_en; done asserts exactly 10 cycles after the cycle start is sampled.
REQ-043 N=4, reversed [3,2,1,0] -> 6 swap pairs (12 wr_en pulses); 30 cycles in the compare states before DONE.
REQ-044 start held high during the operation of REQ-041 -> no restart; exactly one done pulse; the bench checks that the design ignores the held start.
REQ-045 rst asserted in SWAP1 -> next cycle busy=0 and wr_en=0; a new start sorts [3,1,2,0] correctly.
REQ-046 N=2, data [5,1] -> one swap; done after 6 cycles; result [1,5].
